fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  MIPS instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of decode.
//  Owns the PC and issues req/ack fetches to instruction memory, which may take zero or more wait cycles.
//  Feeds inst_D / PC_plus_4_D to decode and takes next_br_D / pc_src_D back from it for redirects.
//  Honours hazard-unit stall/flush; a HOLD buffer prevents refetch during stalls.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0000  instruction word used for bubbles
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   asynchronous, active-high reset
//  stall_F      in   1   hold PC and fetch FSM
//  stall_D      in   1   hold IF/ID register
//  flush_D      in   1   load bubble into IF/ID
//  pc_src_D     in   1   take redirect target from decode
//  next_br_D    in   32  redirect target from decode
//  imem_addr    out  32  fetch address (word aligned)
//  imem_req     out  1   fetch request
//  imem_rdata   in   32  instruction word, valid while imem_ack=1
//  imem_ack     in   1   request complete; may rise in the same cycle as imem_req
//  inst_D       out  32  IF/ID instruction
//  PC_plus_4_D  out  32  IF/ID PC+4
//  valid_D      out  1   IF/ID holds a real instruction
//  pc_F         out  32  current fetch PC
//  fetch_busy   out  1   request outstanding without ack this cycle
// BEHAVIOUR
//  Reset (async): pc_F=RESET_PC, state=IDLE, inst_D=NOP_INST, PC_plus_4_D=0, valid_D=0,
//   hold buffer empty. Counters (if enabled) reset to 0.
//  FSM states: IDLE, REQ, HOLD, DRAIN.
//   IDLE: imem_req=0. Go to REQ on the next cycle after reset releases.
//   REQ:  imem_req=1, imem_addr=pc_F, stable until ack.
//    ack & !stall_F: deliver imem_rdata; pc_F<=pc_src_D?next_br_D:pc_F+4; stay REQ.
//    ack & stall_F: capture rdata and pc_F+4 into the hold buffer; go to HOLD.
//    !ack & pc_src_D & !stall_F: pc_F<=next_br_D; go to DRAIN.
//   HOLD: imem_req=0.
//    !stall_F: deliver buffer; pc_F<=pc_src_D?next_br_D:pc_F+4; go to REQ.
//   DRAIN: imem_req=1 at the old address until ack. Discard the ack data; go to REQ (new pc_F).
//    A further pc_src_D in DRAIN only updates pc_F.
//  stall_F dominates. pc_src_D is ignored while stall_F=1; decode re-asserts it after the stall.
//  Redirect in the same cycle as ack & !stall_F: the acked instruction is still delivered.
//   The hazard unit kills it with flush_D.
//  IF/ID update priority, per cycle:
//   1. flush_D: NOP_INST, valid 0 (beats stall_D).
//   2. stall_D: hold.
//   3. deliver: instruction word, PC+4 of its address, valid 1.
//   4. Otherwise: bubble (NOP_INST, valid 0; PC_plus_4_D holds).
//  Deliveries never occur while stall_F=1. The hazard unit asserts stall_F whenever it asserts stall_D.
//  PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. next_br_D[1:0] is forced to 00.
//  fetch_busy = (state==REQ|DRAIN) & !imem_ack. It is informational only.
//  Latency: a zero-wait memory gives one instruction per cycle. inst_D appears the cycle after ack.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds ports fetch_cnt (out 32) and wait_cnt (out 32).
//   fetch_cnt counts deliveries with valid=1. wait_cnt counts cycles with fetch_busy=1.
//   Both wrap at 2^32 and are async-cleared by reset.
//  FETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Zero-wait memory (ack=req), RESET_PC=0, release reset -> imem_addr 0,4,8,... one per cycle;
//     valid_D=1 from the 2nd cycle after IDLE, PC_plus_4_D 4,8,12.
//  2. Ack two cycles after req -> fetch_busy=1 for 2 cycles, bubbles (valid_D=0) in between,
//     each address requested exactly once.
//  3. stall_F=stall_D=1 for 3 cycles with ack in the 1st -> HOLD, imem_req=0, inst_D held;
//     after release the buffered word is delivered, next req at pc+4.
//  4. pc_src_D=1, next_br_D=0x40 while a req at 0x10 is pending -> DRAIN, ack data dropped
//     (valid_D=0), next req addr 0x40.
//  5. flush_D=1 and stall_D=1 together -> inst_D=NOP_INST, valid_D=0.
//     pc_src_D under stall_F -> pc_F unchanged.
//  6. Reset asserted mid-DRAIN -> outputs reset immediately (no clock), pc_F=RESET_PC;
//     with FETCH_PERF_EN, counters=0 and after test 1, fetch_cnt equals the delivered count.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register, req/ack imem port and stall HOLD buffer.
// Optional macro FETCH_PERF_EN adds the fetch_cnt / wait_cnt performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        pc_src_D,
    input  logic [31:0] next_br_D,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst_D,
    output logic [31:0] PC_plus_4_D,
    output logic        valid_D,
    output logic [31:0] pc_F,
    output logic        fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] wait_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_drain_addr;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc4;
    logic [31:0] r_inst_D;
    logic [31:0] r_pc4_D;
    logic        r_valid_D;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_seq_or_br;
    logic        w_deliver;
    logic [31:0] w_dlv_inst;
    logic [31:0] w_dlv_pc4;
    logic        w_capture;
    logic        w_to_drain;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = next_br_D & 32'hFFFF_FFFC;
    assign w_seq_or_br = pc_src_D ? w_br_target : w_pc_plus4;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_deliver   = 1'b0;
        w_dlv_inst  = imem_rdata;
        w_dlv_pc4   = w_pc_plus4;
        w_capture   = 1'b0;
        w_to_drain  = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (stall_F) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        w_pc_nxt  = w_seq_or_br;
                    end
                end else if (pc_src_D && !stall_F) begin
                    w_pc_nxt    = w_br_target;
                    w_to_drain  = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (!stall_F) begin
                    w_deliver   = 1'b1;
                    w_dlv_inst  = r_hold_inst;
                    w_dlv_pc4   = r_hold_pc4;
                    w_pc_nxt    = w_seq_or_br;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                // The in-flight fetch belongs to the abandoned path; its data is dropped on ack.
                if (pc_src_D && !stall_F) w_pc_nxt = w_br_target;
                if (imem_ack) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // NOTE: the hold buffer is reset too, so its contents are never X even though the FSM guards reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_inst  <= 32'd0;
            r_hold_pc4   <= 32'd0;
            r_drain_addr <= 32'd0;
        end else begin
            if (w_capture) begin
                r_hold_inst <= imem_rdata;
                r_hold_pc4  <= w_pc_plus4;
            end
            if (w_to_drain) r_drain_addr <= r_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_D  <= NOP_INST;
            r_pc4_D   <= 32'd0;
            r_valid_D <= 1'b0;
        end else if (flush_D) begin
            r_inst_D  <= NOP_INST;
            r_valid_D <= 1'b0;
        end else if (stall_D) begin
            r_valid_D <= r_valid_D;
        end else if (w_deliver) begin
            r_inst_D  <= w_dlv_inst;
            r_pc4_D   <= w_dlv_pc4;
            r_valid_D <= 1'b1;
        end else begin
            r_inst_D  <= NOP_INST;
            r_valid_D <= 1'b0;
        end
    end

    assign imem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign fetch_busy  = imem_req && !imem_ack;
    assign pc_F        = r_pc;
    assign inst_D      = r_inst_D;
    assign PC_plus_4_D = r_pc4_D;
    assign valid_D     = r_valid_D;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= 32'd0;
            r_wait_cnt  <= 32'd0;
        end else begin
            if (w_deliver && !flush_D) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (fetch_busy) r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign wait_cnt  = r_wait_cnt;
`endif

endmodule
